// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared widths and helpers for the UART receive buffer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_ERR_CNT_WIDTH = 8;

  // Index bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sat_counter.sv
// ---------------------------------------------------------------------------
// uart_sat_counter : pulse counter that sticks at all-ones; clear wins.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo : FWFT byte FIFO between UART receiver and CPU, with error counts.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = UART_DATA_WIDTH,
  parameter int DEPTH         = UART_RX_FIFO_DEPTH,
  parameter int ERR_CNT_WIDTH = UART_ERR_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  input  logic                           flush,
  input  logic                           clr_err,
  input  logic                           overrun_error_in,
  input  logic                           frame_error_in,
  output logic [ptr_width(DEPTH)-1:0]    count,
  output logic                           full,
  output logic                           empty,
  output logic [ERR_CNT_WIDTH-1:0]       overrun_cnt,
  output logic [ERR_CNT_WIDTH-1:0]       frame_err_cnt
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  assign count         = wr_ptr - rd_ptr;
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign s_axis_tready = !full && !flush;
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = mem[rd_ptr[AW-1:0]];

  // Flush already blocks push through tready; pop must be masked explicitly.
  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
  end

  uart_sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_overrun_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (overrun_error_in),
    .clr   (clr_err),
    .value (overrun_cnt)
  );

  uart_sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_frame_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_error_in),
    .clr   (clr_err),
    .value (frame_err_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo : directed table, corner sequences and random traffic vs a queue model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int EW    = 8;
  localparam int PW    = $clog2(DEPTH) + 1;
  localparam int EMAX  = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic          overrun_error_in = 1'b0;
  logic          frame_error_in = 1'b0;
  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic [EW-1:0] overrun_cnt;
  logic [EW-1:0] frame_err_cnt;

  uart_rx_fifo dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .flush            (flush),
    .clr_err          (clr_err),
    .overrun_error_in (overrun_error_in),
    .frame_error_in   (frame_error_in),
    .count            (count),
    .full             (full),
    .empty            (empty),
    .overrun_cnt      (overrun_cnt),
    .frame_err_cnt    (frame_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, counters as plain integers.
  logic [DW-1:0] q[$];
  int m_ovr = 0;
  int m_frm = 0;

  typedef struct {
    bit          sv;
    logic [7:0]  sd;
    bit          mr;
    int          ecount;
    bit          evalid;
    logic [7:0]  ehead;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic drive(input bit sv, input logic [7:0] sd, input bit mr,
                       input bit fl, input bit cl, input bit ov, input bit fe);
    s_axis_tvalid    = sv;
    s_axis_tdata     = sd;
    m_axis_tready    = mr;
    flush            = fl;
    clr_err          = cl;
    overrun_error_in = ov;
    frame_error_in   = fe;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr = 0;
    m_frm = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, int'(count), q.size());
    chk({tag, "_empty"}, int'(empty), int'(q.size() == 0));
    chk({tag, "_full"},  int'(full),  int'(q.size() == DEPTH));
    chk({tag, "_tvalid"}, int'(m_axis_tvalid), int'(q.size() > 0));
    if (q.size() > 0) chk({tag, "_tdata"}, int'(m_axis_tdata), int'(q[0]));
    chk({tag, "_ovr_cnt"}, int'(overrun_cnt), m_ovr);
    chk({tag, "_frm_cnt"}, int'(frame_err_cnt), m_frm);
  endtask

  // One clock with the currently driven inputs; checks ready before the edge
  // and the whole visible state after it.
  task automatic tick(input string tag);
    bit do_push, do_pop;
    #1;
    chk({tag, "_tready"}, int'(s_axis_tready), int'(q.size() < DEPTH && !flush));
    chk({tag, "_pre_tvalid"}, int'(m_axis_tvalid), int'(q.size() > 0));
    do_push = s_axis_tvalid && (q.size() < DEPTH) && !flush;
    do_pop  = m_axis_tready && (q.size() > 0) && !flush;
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(s_axis_tdata);
    end
    if (clr_err) begin
      m_ovr = 0;
      m_frm = 0;
    end else begin
      if (overrun_error_in && m_ovr < EMAX) m_ovr++;
      if (frame_error_in && m_frm < EMAX) m_frm++;
    end
    check_state(tag);
  endtask

  initial begin
    vecs[0] = '{1, 8'h41, 0, 1, 1, 8'h41};
    vecs[1] = '{1, 8'h42, 0, 2, 1, 8'h41};
    vecs[2] = '{1, 8'h43, 0, 3, 1, 8'h41};
    vecs[3] = '{0, 8'h00, 1, 2, 1, 8'h42};
    vecs[4] = '{0, 8'h00, 1, 1, 1, 8'h43};
    vecs[5] = '{0, 8'h00, 1, 0, 0, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_tready", int'(s_axis_tready), 1);
    chk("rst_ovr", int'(overrun_cnt), 0);
    chk("rst_frm", int'(frame_err_cnt), 0);

    // Directed table: three pushes then three pops.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].sv, vecs[i].sd, vecs[i].mr, 0, 0, 0, 0);
      tick("tbl");
      chk("tbl_count", int'(count), vecs[i].ecount);
      chk("tbl_valid", int'(m_axis_tvalid), int'(vecs[i].evalid));
      if (vecs[i].evalid) chk("tbl_head", int'(m_axis_tdata), int'(vecs[i].ehead));
    end

    // Fill to full, then offer a byte alongside a pop.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'(i), 0, 0, 0, 0, 0);
      tick("fill");
    end
    chk("full_flag", int'(full), 1);
    chk("full_tready", int'(s_axis_tready), 0);
    drive(1, 8'hAA, 1, 0, 0, 0, 0);
    tick("full_pop");
    chk("full_pop_count", int'(count), DEPTH - 1);
    chk("full_pop_head", int'(m_axis_tdata), 1);
    drive(1, 8'hAA, 0, 0, 0, 0, 0);
    tick("full_acc");
    chk("full_acc_count", int'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("drain_last", int'(m_axis_tdata), 8'hAA);
      drive(0, 0, 1, 0, 0, 0, 0);
      tick("drain");
    end

    // Streaming across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'($urandom), 1, 0, 0, 0, 0);
      tick("stream");
      chk("stream_count_le1", int'(count <= 1), 1);
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    tick("stream_end");

    // Flush with a concurrent push.
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h10 + 8'(i), 0, 0, 0, 0, 0);
      tick("pre_flush");
    end
    drive(1, 8'h99, 1, 1, 0, 0, 0);
    tick("flush");
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    drive(1, 8'h55, 0, 0, 0, 0, 0);
    tick("post_flush");
    chk("post_flush_head", int'(m_axis_tdata), 8'h55);
    chk("post_flush_count", int'(count), 1);
    drive(0, 0, 1, 0, 0, 0, 0);
    tick("post_flush_pop");

    // Overrun counter saturation and clear-wins.
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      tick("ovr");
    end
    chk("ovr_sat", int'(overrun_cnt), 255);
    chk("ovr_frm_untouched", int'(frame_err_cnt), 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    tick("clr");
    chk("clr_ovr", int'(overrun_cnt), 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 47) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      tick("rand");
    end

    // Asynchronous reset mid-cycle with data and errors present.
    drive(0, 0, 0, 1, 0, 0, 0);
    tick("ar_flush");
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hC0 + 8'(i), 0, 0, 0, 1, 1);
      tick("ar_fill");
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_count", int'(count), 0);
    chk("ar_tvalid", int'(m_axis_tvalid), 0);
    chk("ar_ovr", int'(overrun_cnt), 0);
    chk("ar_frm", int'(frame_err_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 8'h77, 0, 0, 0, 0, 0);
    tick("ar_after");
    drive(0, 0, 1, 0, 0, 0, 0);
    tick("ar_after_pop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Accepts received bytes on an AXI4-Stream slave port.
- Stores them in a first-word-fall-through FIFO and presents them on an AXI4-Stream master port to the CPU MMIO read path.
- Keeps saturating counts of overrun and frame-error pulses from the receiver so software can detect lost or corrupted bytes.

Parameters:
- DATA_WIDTH, 8, byte width; must match the receiver.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- ERR_CNT_WIDTH, 8, width of each saturating error counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  byte from receiver.
- s_axis_tvalid  in  1  receiver byte valid.
- s_axis_tready  out  1  FIFO can accept.
- m_axis_tdata  out  DATA_WIDTH  head-of-FIFO byte.
- m_axis_tvalid  out  1  FIFO non-empty.
- m_axis_tready  in  1  consumer pops head.
- flush  in  1  synchronous discard of all contents.
- clr_err  in  1  synchronous clear of both error counters.
- overrun_error_in  in  1  single-cycle pulse from receiver.
- frame_error_in  in  1  single-cycle pulse from receiver.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overrun_cnt  out  ERR_CNT_WIDTH  saturating overrun pulse count.
- frame_err_cnt  out  ERR_CNT_WIDTH  saturating frame-error pulse count.

Behaviour:
- Clock and reset: clk is the single clock. rst_n is asynchronous active-low, asserted asynchronously and released synchronously by the top level.
- Reset values:
  - Pointers 0, count 0, empty 1, full 0.
  - m_axis_tvalid 0, s_axis_tready 1.
  - Both error counters 0.
  - Storage contents are don't-care; m_axis_tdata is don't-care while m_axis_tvalid = 0.
- Storage and pointers: register array of DEPTH entries. Write and read pointers are $clog2(DEPTH)+1 bits; the MSB is a wrap bit. count = wr_ptr - rd_ptr (modulo). full when the index bits are equal and the wrap bits differ.
- Push: s_axis_tvalid && s_axis_tready. s_axis_tready = !full && !flush.
- Pop: m_axis_tvalid && m_axis_tready. m_axis_tvalid = !empty. m_axis_tdata = mem[rd_ptr index], a combinational read of registered storage.
- Latency: a byte pushed in cycle N appears on m_axis_tvalid/m_axis_tdata in cycle N+1. A pop in cycle N advances the head in cycle N+1.
- Simultaneous push and pop: both take effect and count is unchanged. When full, no push is accepted in that cycle even if a pop occurs; s_axis_tready depends only on registered state, with no combinational ready-through path.
- Full: the receiver holds its tvalid and reports overrun itself. No data is lost inside this block and no byte is overwritten.
- Pointer wrap: pointers wrap modulo 2*DEPTH. Sequences longer than DEPTH preserve order.
- Flush: in the flush cycle, both pointers are reset to 0 and any concurrent push or pop is ignored. The FIFO is empty from the next cycle. Error counters are unaffected.
- Error counters: each increments by 1 on its input pulse and saturates at all-ones, with no wrap. If clr_err coincides with a pulse, clear wins and the result is 0. The counters are independent of flush.
- Reset mid-operation: asynchronous clear of all state. Any in-flight handshake is abandoned with no partial pop.
- Handshake rule: AXI4-Stream. A master may not drop tvalid before handshake; this block's m_axis_tdata is stable while m_axis_tvalid && !m_axis_tready.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_WIDTH = 8.
  - UART_RX_FIFO_DEPTH = 16.
  - UART_ERR_CNT_WIDTH = 8.
  - Derived pointer width: localparam function of DEPTH.
- One sub-module: uart_sat_counter (parameter WIDTH; ports clk, rst_n, inc, clr, value), instantiated twice for the two error counters.

Test Plan:
- Reset, then push 0x41,0x42,0x43 with m_axis_tready=0 -> count=3, m_axis_tdata=0x41, m_axis_tvalid rises 1 cycle after the first push. Pop three -> 0x41,0x42,0x43 in order, then empty=1.
- Push 16 bytes 0x00..0x0F -> full=1, s_axis_tready=0. Offer 0xAA with a simultaneous pop -> 0x00 popped, 0xAA not accepted, count=15. Next cycle 0xAA is accepted, count=16.
- Stream 40 bytes with continuous pop (tready=1) -> output equals input sequence across pointer wrap, count stays <=1.
- Fill 5 bytes, assert flush for 1 cycle with s_axis_tvalid=1 -> next cycle count=0, empty=1, flushed byte absent. A subsequent push of 0x55 is read back as 0x55.
- 300 overrun_error_in pulses -> overrun_cnt=255 (saturated). Then clr_err with a coincident pulse -> 0. frame_err_cnt unaffected throughout.
- Deassert rst_n asynchronously mid-cycle with 4 bytes stored -> count=0, m_axis_tvalid=0, counters=0 immediately without waiting for a clk edge.
